// File: rtl/video_pkg.sv
// Shared definitions for the raster timing generator: pattern mode codes,
// the colour-bar table and the bounce step used by the optional moving box.
package video_pkg;

  typedef logic [23:0] rgb_t;

  localparam logic [2:0] MODE_SOLID    = 3'd0;
  localparam logic [2:0] MODE_BARS     = 3'd1;
  localparam logic [2:0] MODE_GRID     = 3'd2;
  localparam logic [2:0] MODE_GRADIENT = 3'd3;

  // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb_t BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // One frame step of a bouncing coordinate; returns {up_next, pos_next}.
  function automatic logic [12:0] bounce_step(input logic [11:0] pos,
                                              input logic        up,
                                              input logic [11:0] limit);
    if (up) begin
      if (pos >= limit) return {1'b0, pos - 12'd1};
      else              return {1'b1, pos + 12'd1};
    end else begin
      if (pos == 12'd0) return {1'b1, pos + 12'd1};
      else              return {1'b0, pos - 12'd1};
    end
  endfunction

endpackage

// File: rtl/video_pattern.sv
// Combinational test-pattern colour for one raster position, blanked outside
// the visible area. The inverting box exists only when VTG_BOUNCE_EN is defined.
module video_pattern
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 390,
`ifdef VTG_BOUNCE_EN
  parameter int BOX_SIZE  = 32,
`endif
  parameter int GRID_LOG2 = 4
) (
  input  logic [11:0] cx,
  input  logic [11:0] cy,
  input  logic [2:0]  mode,
  input  rgb_t        solid,
  input  logic [7:0]  frame_cnt,
`ifdef VTG_BOUNCE_EN
  input  logic [11:0] box_x,
  input  logic [11:0] box_y,
`endif
  output logic        draw,
  output rgb_t        rgb
);

  logic [7:1] past_edge;
  logic [2:0] bar_idx;
  logic       grid_on;
  rgb_t       base;
  rgb_t       shown;

  // Bar boundaries are constants, so each edge is a single comparator.
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
    assign past_edge[gi] = ({1'b0, cx} >= 13'((gi * H_ACTIVE) / 8));
  end

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (past_edge[k]) bar_idx = 3'(k);
    end
  end

  assign grid_on = (cx[GRID_LOG2-1:0] == '0) || (cy[GRID_LOG2-1:0] == '0);
  assign draw    = ({1'b0, cx} < 13'(H_ACTIVE)) && ({1'b0, cy} < 13'(V_ACTIVE));

  always_comb begin
    base = '0;
    case (mode)
      MODE_SOLID:    base = solid;
      MODE_BARS:     base = BAR_TABLE[bar_idx];
      MODE_GRID:     base = grid_on ? 24'hFFFFFF : 24'h000000;
      MODE_GRADIENT: base = {cx[7:0], cy[7:0], frame_cnt};
      default:       base = '0;
    endcase
  end

`ifdef VTG_BOUNCE_EN
  logic in_box;
  assign in_box = ({1'b0, cx} >= {1'b0, box_x}) && ({1'b0, cx} < {1'b0, box_x} + 13'(BOX_SIZE)) &&
                  ({1'b0, cy} >= {1'b0, box_y}) && ({1'b0, cy} < {1'b0, box_y} + 13'(BOX_SIZE));
  assign shown  = in_box ? ~base : base;
`else
  assign shown  = base;
`endif

  assign rgb = draw ? shown : '0;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with selectable test pattern; all outputs registered
// once (latency 1). Define VTG_BOUNCE_EN to add the bouncing inverted box.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 32,
  parameter int H_SYNC    = 96,
  parameter int H_TOTAL   = 1440,
  parameter int V_ACTIVE  = 390,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 24,
  parameter int V_TOTAL   = 442,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int GRID_LOG2 = 4,
  parameter int BOX_SIZE  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        DrawArea,
  output logic        hSync,
  output logic        vSync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  if (H_ACTIVE + H_FP + H_SYNC > H_TOTAL || H_TOTAL > 4096 || H_ACTIVE < 8) begin : g_bad_h
    $error("video_timing_gen: illegal horizontal timing parameters");
  end
  if (V_ACTIVE + V_FP + V_SYNC > V_TOTAL || V_TOTAL > 4096 || V_ACTIVE < 1) begin : g_bad_v
    $error("video_timing_gen: illegal vertical timing parameters");
  end
  if (GRID_LOG2 < 1 || GRID_LOG2 > 8 || BOX_SIZE < 1) begin : g_bad_pattern
    $error("video_timing_gen: illegal pattern parameters");
  end

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] cx_reg, cy_reg;
  logic [7:0]  frame_cnt_reg;
  logic [2:0]  mode_reg;
  rgb_t        solid_reg;
  logic        frame_end;
  logic        hs_win, vs_win;
  logic        draw;
  rgb_t        rgb;

  // Last pixel of the frame: mode, colour, frame count and box all advance here.
  assign frame_end = (cx_reg == H_LAST) && (cy_reg == V_LAST);
  assign hs_win    = ({1'b0, cx_reg} >= HS_START) && ({1'b0, cx_reg} < HS_END);
  assign vs_win    = ({1'b0, cy_reg} >= VS_START) && ({1'b0, cy_reg} < VS_END);

`ifdef VTG_BOUNCE_EN
  localparam logic [11:0] BOX_X_MAX = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] BOX_Y_MAX = 12'(V_ACTIVE - BOX_SIZE);

  if (BOX_SIZE >= H_ACTIVE || BOX_SIZE >= V_ACTIVE) begin : g_bad_box
    $error("video_timing_gen: BOX_SIZE must be smaller than the active area");
  end

  logic [11:0] box_x_reg, box_y_reg;
  logic        box_right_reg, box_down_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      box_x_reg     <= '0;
      box_y_reg     <= '0;
      box_right_reg <= 1'b1;
      box_down_reg  <= 1'b1;
    end else if (frame_end) begin
      {box_right_reg, box_x_reg} <= bounce_step(box_x_reg, box_right_reg, BOX_X_MAX);
      {box_down_reg, box_y_reg}  <= bounce_step(box_y_reg, box_down_reg, BOX_Y_MAX);
    end
  end
`endif

  video_pattern #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
`ifdef VTG_BOUNCE_EN
    .BOX_SIZE  (BOX_SIZE),
`endif
    .GRID_LOG2 (GRID_LOG2)
  ) u_pattern (
    .cx        (cx_reg),
    .cy        (cy_reg),
    .mode      (mode_reg),
    .solid     (solid_reg),
    .frame_cnt (frame_cnt_reg),
`ifdef VTG_BOUNCE_EN
    .box_x     (box_x_reg),
    .box_y     (box_y_reg),
`endif
    .draw      (draw),
    .rgb       (rgb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cx_reg        <= '0;
      cy_reg        <= '0;
      frame_cnt_reg <= '0;
      mode_reg      <= MODE_SOLID;
      solid_reg     <= '0;
      DrawArea      <= 1'b0;
      hSync         <= ~HS_POL;
      vSync         <= ~VS_POL;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      frame_start   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      if (cx_reg == H_LAST) begin
        cx_reg <= '0;
        cy_reg <= (cy_reg == V_LAST) ? 12'd0 : cy_reg + 12'd1;
      end else begin
        cx_reg <= cx_reg + 12'd1;
      end
      if (frame_end) begin
        mode_reg      <= mode;
        solid_reg     <= solid_rgb;
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
      DrawArea           <= draw;
      hSync              <= hs_win ? HS_POL : ~HS_POL;
      vSync              <= vs_win ? VS_POL : ~VS_POL;
      {red, green, blue} <= rgb;
      pix_x              <= cx_reg;
      pix_y              <= cy_reg;
      frame_start        <= (cx_reg == 12'd0) && (cy_reg == 12'd0);
      frame_cnt          <= frame_cnt_reg;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 40x12 raster (32x8 visible).
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        DrawArea, hSync, vSync, frame_start;
  logic [7:0]  red, green, blue, frame_cnt;
  logic [11:0] pix_x, pix_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE (32), .H_FP (2), .H_SYNC (4), .H_TOTAL (40),
    .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_TOTAL (12),
    .HS_POL (1'b1), .VS_POL (1'b1), .GRID_LOG2 (2), .BOX_SIZE (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .DrawArea    (DrawArea),
    .hSync       (hSync),
    .vSync       (vSync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [23:0] exp);
    check(tag, {8'h0, red, green, blue}, {8'h0, exp});
  endtask

  // Advance to the negedge where pixel (x,y) is on the outputs, bounded.
  task automatic wait_pix(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pix_x == 12'(x) && pix_y == 12'(y)) && n < 1000);
    if (!(pix_x == 12'(x) && pix_y == 12'(y))) begin
      checks++;
      errors++;
      $error("FAIL wait_pix: observed=(%0d,%0d) expected=(%0d,%0d)", pix_x, pix_y, x, y);
    end else begin
      $display("pix (%0d,%0d) frame=%0d de=%b hs=%b vs=%b rgb=%h",
               x, y, frame_cnt, DrawArea, hSync, vSync, {red, green, blue});
    end
  endtask

  initial begin
    int fs_cnt, de_cnt, hs_cnt, vs_cnt, rgb_nz, hs_first, vs_first;
    logic hs_prev, vs_prev;

    solid_rgb = 24'h123456;
    mode      = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_de", DrawArea, 1'b0);
    check("rst_hs", hSync, 1'b0);
    check("rst_vs", vSync, 1'b0);
    check_rgb("rst_rgb", 24'h0);
    check("rst_px", pix_x, 12'd0);
    check("rst_py", pix_y, 12'd0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_fc", frame_cnt, 8'd0);

    // Frame 0: sweep every output clock and tally the timing signals.
    reset = 1'b0;
    fs_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; rgb_nz = 0;
    hs_first = 0; vs_first = 0; hs_prev = 1'b0; vs_prev = 1'b0;
    for (int i = 1; i <= 480; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("first_de", DrawArea, 1'b1);
        check("first_fs", frame_start, 1'b1);
        check("first_px", pix_x, 12'd0);
        check("first_py", pix_y, 12'd0);
        check_rgb("first_rgb", 24'h0);
      end
      if (frame_start) fs_cnt++;
      if (DrawArea) de_cnt++;
      if (hSync) hs_cnt++;
      if (vSync) vs_cnt++;
      if ({red, green, blue} != 24'h0) rgb_nz++;
      if (hSync && !hs_prev && hs_first == 0) hs_first = i;
      if (vSync && !vs_prev && vs_first == 0) vs_first = i;
      hs_prev = hSync;
      vs_prev = vSync;
    end
    $display("frame0 fs=%0d de=%0d hs=%0d vs=%0d hs_first=%0d vs_first=%0d",
             fs_cnt, de_cnt, hs_cnt, vs_cnt, hs_first, vs_first);
    check("f0_fs_cnt", fs_cnt, 1);
    check("f0_de_cnt", de_cnt, 256);
    check("f0_hs_cnt", hs_cnt, 48);
    check("f0_vs_cnt", vs_cnt, 80);
    check("f0_hs_first", hs_first, 35);
    check("f0_vs_first", vs_first, 361);
    check("f0_rgb_black", rgb_nz, 0);

    // Frame 1 begins exactly one frame period later, now solid 123456.
    @(negedge clk);
    check("f1_fs", frame_start, 1'b1);
    check("f1_fc", frame_cnt, 8'd1);
    check_rgb("f1_rgb00", 24'h123456);
    wait_pix(5, 2);
    check_rgb("f1_rgb52", 24'h123456);
    mode = 3'd1;
    wait_pix(10, 6);
    check_rgb("f1_after_change", 24'h123456);
    check("f1_fc_mid", frame_cnt, 8'd1);

    // Frame 2: colour bars, 4 pixels per bar.
    wait_pix(0, 0);
    check("f2_fs", frame_start, 1'b1);
    check("f2_fc", frame_cnt, 8'd2);
    check_rgb("bar_x0", 24'hFFFFFF);
    wait_pix(3, 0);
    check_rgb("bar_x3", 24'hFFFFFF);
    wait_pix(4, 0);
    check_rgb("bar_x4", 24'hFFFF00);
    wait_pix(8, 0);
    check_rgb("bar_x8", 24'h00FFFF);
    wait_pix(27, 1);
    check_rgb("bar_x27", 24'h0000FF);
    wait_pix(28, 1);
    check_rgb("bar_x28", 24'h000000);
    wait_pix(31, 1);
    check("x31_de", DrawArea, 1'b1);
    wait_pix(32, 1);
    check("x32_de", DrawArea, 1'b0);
    wait_pix(33, 1);
    check_rgb("blank_rgb", 24'h0);
    check("x33_hs", hSync, 1'b0);
    wait_pix(34, 1);
    check("x34_hs", hSync, 1'b1);
    wait_pix(37, 1);
    check("x37_hs", hSync, 1'b1);
    wait_pix(38, 1);
    check("x38_hs", hSync, 1'b0);
    wait_pix(39, 8);
    check("y8_vs", vSync, 1'b0);
    wait_pix(0, 9);
    check("y9_vs", vSync, 1'b1);
    check("y9_de", DrawArea, 1'b0);
    wait_pix(0, 11);
    check("y11_vs", vSync, 1'b0);
    mode = 3'd3;

    // Frame 3: gradient.
    wait_pix(0, 0);
    check("f3_fc", frame_cnt, 8'd3);
    wait_pix(30, 5);
    check_rgb("grad_30_5", 24'h1E0503);
    mode = 3'd2;

    // Frame 4: grid with 4-pixel pitch.
    wait_pix(4, 1);
    check_rgb("grid_4_1", 24'hFFFFFF);
    wait_pix(5, 1);
    check_rgb("grid_5_1", 24'h000000);
    wait_pix(5, 4);
    check_rgb("grid_5_4", 24'hFFFFFF);
    mode = 3'd5;

    // Frame 5: undefined mode is black.
    wait_pix(6, 2);
    check_rgb("mode5_rgb", 24'h000000);
    check("mode5_de", DrawArea, 1'b1);
    mode = 3'd0;

    // Frame 6: solid again, then reset while both syncs are active.
    wait_pix(1, 1);
    check_rgb("f6_rgb", 24'h123456);
    check("f6_fc", frame_cnt, 8'd6);
    wait_pix(35, 9);
    check("pre_rst_hs", hSync, 1'b1);
    check("pre_rst_vs", vSync, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_hs", hSync, 1'b0);
      check("mid_rst_vs", vSync, 1'b0);
      check("mid_rst_px", pix_x, 12'd0);
      check("mid_rst_fc", frame_cnt, 8'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("restart_fs", frame_start, 1'b1);
    check("restart_px", pix_x, 12'd0);
    check("restart_py", pix_y, 12'd0);
    check("restart_fc", frame_cnt, 8'd0);
    check("restart_de", DrawArea, 1'b1);
    check_rgb("restart_rgb", 24'h0);
    @(negedge clk);
    check("restart_px1", pix_x, 12'd1);
    check("restart_fs1", frame_start, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
